aclk_time_counter: RTL and testbench



---
 rtl/aclk_time_pkg.sv | 25 ++
 rtl/aclk_bcd_digit.sv | 39 +++
 rtl/aclk_time_counter.sv | 177 +++++++++++++++++
 tb/tb_aclk_time_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/aclk_time_pkg.sv
// Shared types and constants for the alarm-clock current-time counter.
// Optional 12-hour build is selected with the ACLK_12H_MODE_EN macro.
package aclk_time_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX  = 4'd9;
  localparam bcd_digit_t SEC_MS_MAX = 4'd5;
  localparam bcd_digit_t MIN_MS_MAX = 4'd5;
  localparam logic [7:0] HR24_MAX   = 8'd23;
  localparam logic [7:0] HR12_MAX   = 8'd12;

  // Digit positions within the 24-bit {hh,mm,ss} packing (4 bits each)
  localparam int unsigned LS_SEC_IDX = 0;
  localparam int unsigned MS_SEC_IDX = 1;
  localparam int unsigned LS_MIN_IDX = 2;
  localparam int unsigned MS_MIN_IDX = 3;
  localparam int unsigned LS_HR_IDX  = 4;
  localparam int unsigned MS_HR_IDX  = 5;

  function automatic bcd_digit_t digit_at(input logic [23:0] t, input int unsigned idx);
    return t[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/aclk_bcd_digit.sv
// One BCD digit: load has priority over count-enable; wraps to 0 past max_i.
module aclk_bcd_digit
  import aclk_time_pkg::*;
#(
  parameter bcd_digit_t RST_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  bcd_digit_t max_i,
  output bcd_digit_t q_o,
  output logic       co_o
);

  bcd_digit_t digit_q, digit_d;

  // Wrap on >= so an out-of-range unchecked load still converges to 0
  assign co_o = en_i && (digit_q >= max_i);
  assign q_o  = digit_q;

  // Next digit value: load, else count with wrap
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (en_i) begin
      digit_d = (digit_q >= max_i) ? '0 : digit_q + 4'd1;
    end
  end

  // Digit register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) digit_q <= RST_VAL;
    else       digit_q <= digit_d;
  end

endmodule

// File: rtl/aclk_time_counter.sv
// HH:MM:SS BCD current-time counter with prescaled advance, validated load
// and minute/hour/day rollover strobes.
// Define ACLK_12H_MODE_EN for the 12-hour (12,01..11 + pm) build.
module aclk_time_counter
  import aclk_time_pkg::*;
#(
  parameter int unsigned PRESCALE   = 1,
  parameter bit          LOAD_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        load_new_c,
  input  logic [23:0] new_time,
  input  logic        new_pm,
  output logic [23:0] current_time,
  output logic        pm,
  output logic        minute_pulse,
  output logic        hour_pulse,
  output logic        day_pulse,
  output logic        load_err
);

  localparam int unsigned PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

`ifdef ACLK_12H_MODE_EN
  localparam bcd_digit_t RST_LS_HR = 4'd2;
  localparam bcd_digit_t RST_MS_HR = 4'd1;
`else
  localparam bcd_digit_t RST_LS_HR = 4'd0;
  localparam bcd_digit_t RST_MS_HR = 4'd0;
`endif

  logic [PW-1:0] ps_q, ps_d;
  logic          minute_q, hour_q, day_q, err_q;
  logic          adv, load_ok, load_acc, load_rej;
  logic          hr_force, day_wrap;
  bcd_digit_t    hr_force_ls, hr_force_ms;
  logic [7:0]    hr_bin_q, hr_bin_new;
  bcd_digit_t    nd   [6];
  bcd_digit_t    dq   [6];
  bcd_digit_t    dmax [6];
  bcd_digit_t    dval [6];
  logic          den  [6];
  logic          dload[6];
  logic          dco  [6];
  logic          new_valid;

  // Load decode and validity of the requested time
  always_comb begin
    for (int unsigned i = 0; i < 6; i++) nd[i] = digit_at(new_time, i);
    hr_bin_new = {4'd0, nd[MS_HR_IDX]} * 8'd10 + {4'd0, nd[LS_HR_IDX]};
    new_valid = (nd[MS_SEC_IDX] <= SEC_MS_MAX) && (nd[MS_MIN_IDX] <= MIN_MS_MAX);
    for (int unsigned i = 0; i < 6; i++) begin
      if (nd[i] > DIGIT_MAX) new_valid = 1'b0;
    end
`ifdef ACLK_12H_MODE_EN
    if (hr_bin_new == 8'd0 || hr_bin_new > HR12_MAX) new_valid = 1'b0;
`else
    if (hr_bin_new > HR24_MAX) new_valid = 1'b0;
`endif
    load_ok  = !LOAD_CHECK || new_valid;
    load_acc = load_new_c && load_ok;
    load_rej = load_new_c && !load_ok;
  end

  // Prescaler: a pending load (accepted or not) swallows the tick
  always_comb begin
    adv  = tick_in && (ps_q == PS_LAST) && !load_new_c;
    ps_d = ps_q;
    if (load_acc)         ps_d = '0;
    else if (load_new_c)  ps_d = ps_q;
    else if (tick_in)     ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PW'(1);
  end

  assign hr_bin_q = {4'd0, dq[MS_HR_IDX]} * 8'd10 + {4'd0, dq[LS_HR_IDX]};

`ifdef ACLK_12H_MODE_EN
  logic pm_q, pm_d;
  logic hr_is11, hr_is12;

  // Hour-pair wrap: 11->12 toggles pm, 12->01; day ends when pm falls
  always_comb begin
    hr_is11     = (hr_bin_q == HR12_MAX - 8'd1);
    hr_is12     = (hr_bin_q == HR12_MAX);
    hr_force    = dco[MS_MIN_IDX] && (hr_is11 || hr_is12);
    hr_force_ms = hr_is12 ? 4'd0 : 4'd1;
    hr_force_ls = hr_is12 ? 4'd1 : 4'd2;
    day_wrap    = dco[MS_MIN_IDX] && hr_is11 && pm_q;
    pm_d        = pm_q;
    if (load_acc)                          pm_d = new_pm;
    else if (dco[MS_MIN_IDX] && hr_is11)   pm_d = !pm_q;
  end

  // PM flag register
  always_ff @(posedge clk) begin
    if (reset) pm_q <= 1'b0;
    else       pm_q <= pm_d;
  end

  assign pm = pm_q;
`else
  logic unused_new_pm;

  // Hour-pair wrap: 23 -> 00 closes the day
  always_comb begin
    hr_force    = dco[MS_MIN_IDX] && (hr_bin_q == HR24_MAX);
    hr_force_ms = 4'd0;
    hr_force_ls = 4'd0;
    day_wrap    = hr_force;
  end

  assign unused_new_pm = new_pm;
  assign pm            = 1'b0;
`endif

  // Per-digit enable/load/limit; carries ripple within the same edge
  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      den[i]   = (i == 0) ? adv : dco[i-1];
      dload[i] = load_acc;
      dval[i]  = nd[i];
      dmax[i]  = DIGIT_MAX;
    end
    dmax[MS_SEC_IDX]  = SEC_MS_MAX;
    dmax[MS_MIN_IDX]  = MIN_MS_MAX;
    dload[LS_HR_IDX]  = load_acc || hr_force;
    dload[MS_HR_IDX]  = load_acc || hr_force;
    if (!load_acc) begin
      dval[LS_HR_IDX] = hr_force_ls;
      dval[MS_HR_IDX] = hr_force_ms;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_digit
    aclk_bcd_digit #(
      .RST_VAL((g == LS_HR_IDX) ? RST_LS_HR : (g == MS_HR_IDX) ? RST_MS_HR : 4'd0)
    ) u_digit (
      .clk        (clk),
      .reset      (reset),
      .en_i       (den[g]),
      .load_i     (dload[g]),
      .load_val_i (dval[g]),
      .max_i      (dmax[g]),
      .q_o        (dq[g]),
      .co_o       (dco[g])
    );
  end

  logic unused_co;
  assign unused_co = dco[MS_HR_IDX];

  // Prescaler and one-cycle strobe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q     <= '0;
      minute_q <= 1'b0;
      hour_q   <= 1'b0;
      day_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ps_q     <= ps_d;
      minute_q <= dco[MS_SEC_IDX];
      hour_q   <= dco[MS_MIN_IDX];
      day_q    <= day_wrap;
      err_q    <= load_rej;
    end
  end

  assign current_time = {dq[5], dq[4], dq[3], dq[2], dq[1], dq[0]};
  assign minute_pulse = minute_q;
  assign hour_pulse   = hour_q;
  assign day_pulse    = day_q;
  assign load_err     = err_q;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Directed bench for aclk_time_counter: three instances share stimulus
// (A: PRESCALE=1 checked, B: PRESCALE=4 checked, C: PRESCALE=1 unchecked).
module tb_aclk_time_counter;

`ifdef ACLK_12H_MODE_EN
  localparam logic [23:0] BASE = 24'h120000;
`else
  localparam logic [23:0] BASE = 24'h000000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [23:0] new_time = '0;
  logic        new_pm = 1'b0;

  logic [23:0] ta, tb_t, tc;
  logic        pa, ma, ha, da, ea;
  logic        pb, mb, hb, db, eb;
  logic        pc, mc, hc, dc, ec;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  aclk_time_counter #(.PRESCALE(1), .LOAD_CHECK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .tick_in(tick), .load_new_c(load), .new_time(new_time),
    .new_pm(new_pm), .current_time(ta), .pm(pa), .minute_pulse(ma), .hour_pulse(ha),
    .day_pulse(da), .load_err(ea));

  aclk_time_counter #(.PRESCALE(4), .LOAD_CHECK(1'b1)) dut_b (
    .clk(clk), .reset(reset), .tick_in(tick), .load_new_c(load), .new_time(new_time),
    .new_pm(new_pm), .current_time(tb_t), .pm(pb), .minute_pulse(mb), .hour_pulse(hb),
    .day_pulse(db), .load_err(eb));

  aclk_time_counter #(.PRESCALE(1), .LOAD_CHECK(1'b0)) dut_c (
    .clk(clk), .reset(reset), .tick_in(tick), .load_new_c(load), .new_time(new_time),
    .new_pm(new_pm), .current_time(tc), .pm(pc), .minute_pulse(mc), .hour_pulse(hc),
    .day_pulse(dc), .load_err(ec));

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] t, input logic p);
    load = 1'b1; new_time = t; new_pm = p;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("reset_time", ta, BASE);
    check("reset_strobes", {20'd0, ma, ha, da, ea}, 24'd0);
    check("reset_pm", {23'd0, pa}, 24'd0);

    do_load(24'h123456, 1'b0);
    check("load_time", ta, 24'h123456);
    check("load_no_err", {23'd0, ea}, 24'd0);
    check("load_no_strobe", {21'd0, ma, ha, da}, 24'd0);

`ifndef ACLK_12H_MODE_EN
    do_load(24'h235958, 1'b0);
    tick = 1'b1;
    step();
    check("day_pre", ta, 24'h235959);
    check("day_pre_strobe", {21'd0, ma, ha, da}, 24'd0);
    step();
    tick = 1'b0;
    check("day_wrap", ta, 24'h000000);
    check("day_strobes", {21'd0, ma, ha, da}, 24'h7);
    step();
    check("day_strobes_clear", {21'd0, ma, ha, da}, 24'd0);
    check("pm_24h", {23'd0, pa}, 24'd0);
`endif

    do_load(24'h095959, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("hour_carry", ta, 24'h100000);
    check("hour_strobes", {21'd0, ma, ha, da}, 24'h6);

    // PRESCALE=4 advance pacing
    do_load(BASE, 1'b0);
    tick = 1'b1;
    repeat (3) step();
    check("ps_3ticks", tb_t, BASE);
    step();
    check("ps_4ticks", tb_t, BASE | 24'h1);
    repeat (4) step();
    check("ps_8ticks", tb_t, BASE | 24'h2);
    check("ps1_8ticks", ta, BASE | 24'h8);
    repeat (2) step();
    tick = 1'b0;
    do_load(BASE, 1'b0);
    tick = 1'b1;
    repeat (3) step();
    check("ps_cleared", tb_t, BASE);
    step();
    tick = 1'b0;
    check("ps_after_clear", tb_t, BASE | 24'h1);
    check("ps1_after_clear", ta, BASE | 24'h4);

    // Rejected loads
    load = 1'b1; new_time = 24'h240000;
    step();
    load = 1'b0;
    check("bad_hr_time", ta, BASE | 24'h4);
    check("bad_hr_err", {23'd0, ea}, 24'd1);
    check("bad_hr_nocheck", tc, 24'h240000);
    check("bad_hr_nocheck_err", {23'd0, ec}, 24'd0);
    step();
    check("err_one_cycle", {23'd0, ea}, 24'd0);
    load = 1'b1; new_time = 24'h126000;
    step();
    load = 1'b0;
    check("bad_min_time", ta, BASE | 24'h4);
    check("bad_min_err", {23'd0, ea}, 24'd1);
    check("bad_min_nocheck", tc, 24'h126000);

    // Load beats a coincident tick
    do_load(24'h095959, 1'b0);
    load = 1'b1; new_time = 24'h010000; tick = 1'b1;
    step();
    check("load_vs_tick", ta, 24'h010000);
    check("load_vs_tick_strobe", {20'd0, ma, ha, da, ea}, 24'd0);
    new_time = 24'h240000;
    step();
    check("rej_vs_tick", ta, 24'h010000);
    check("rej_vs_tick_flags", {20'd0, ma, ha, da, ea}, 24'd1);

    // Held load reloads, no advance
    new_time = 24'h111111;
    repeat (3) step();
    load = 1'b0;
    check("hold_load", ta, 24'h111111);

    // Reset mid-count and mid-load
    repeat (2) step();
    reset = 1'b1; load = 1'b1; new_time = 24'h240000;
    step();
    reset = 1'b0; load = 1'b0;
    check("reset_mid_a", ta, BASE);
    check("reset_mid_b", tb_t, BASE);
    check("reset_mid_flags", {20'd0, ma, ha, da, ea}, 24'd0);
    repeat (3) step();
    check("reset_ps_cleared", tb_t, BASE);
    step();
    tick = 1'b0;
    check("reset_ps_adv", tb_t, BASE | 24'h1);

`ifdef ACLK_12H_MODE_EN
    do_load(24'h115959, 1'b0);
    tick = 1'b1; step(); tick = 1'b0;
    check("h12_to_noon", ta, 24'h120000);
    check("h12_pm_set", {23'd0, pa}, 24'd1);
    check("h12_noon_noday", {23'd0, da}, 24'd0);
    do_load(24'h125959, 1'b1);
    tick = 1'b1; step(); tick = 1'b0;
    check("h12_to_one", ta, 24'h010000);
    check("h12_pm_hold", {23'd0, pa}, 24'd1);
    do_load(24'h115959, 1'b1);
    tick = 1'b1; step(); tick = 1'b0;
    check("h12_midnight", ta, 24'h120000);
    check("h12_pm_clear", {23'd0, pa}, 24'd0);
    check("h12_day_strobes", {21'd0, ma, ha, da}, 24'h7);
    do_load(24'h000000, 1'b0);
    check("h12_bad_zero", {23'd0, ea}, 24'd1);
    do_load(24'h130000, 1'b0);
    check("h12_bad_13", {23'd0, ea}, 24'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
